// File: rtl/ssd_segment_decoder.sv
// Seven-segment receive decoder: debounces an active-low segment bus and emits
// each new stable pattern once as a hex digit, dash, blank or error flag.
// Optional error counter is built only when SSD_DECODE_ERR_CNT_EN is defined.
module ssd_segment_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_nibble,
    output logic       out_dash,
    output logic       out_blank,
    output logic       out_err,
    output logic       out_overrun,
    output logic [7:0] err_count
);

    localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Returns {err, blank, dash, nibble} for an active-high segment pattern.
    function automatic logic [6:0] decode_seg(input logic [6:0] raw);
        logic [6:0] res;
        case (raw)
            7'h3F:   res = {3'b000, 4'h0};
            7'h06:   res = {3'b000, 4'h1};
            7'h5B:   res = {3'b000, 4'h2};
            7'h4F:   res = {3'b000, 4'h3};
            7'h66:   res = {3'b000, 4'h4};
            7'h6D:   res = {3'b000, 4'h5};
            7'h7D:   res = {3'b000, 4'h6};
            7'h07:   res = {3'b000, 4'h7};
            7'h7F:   res = {3'b000, 4'h8};
            7'h67:   res = {3'b000, 4'h9};
            7'h77:   res = {3'b000, 4'hA};
            7'h7C:   res = {3'b000, 4'hB};
            7'h39:   res = {3'b000, 4'hC};
            7'h5E:   res = {3'b000, 4'hD};
            7'h79:   res = {3'b000, 4'hE};
            7'h71:   res = {3'b000, 4'hF};
            7'h40:   res = {3'b001, 4'h0};
            7'h00:   res = {3'b010, 4'h0};
            default: res = {3'b100, 4'h0};
        endcase
        return res;
    endfunction

    logic [6:0] seg_q_r;
    logic [7:0] cnt_r;
    logic [6:0] last_pat_r;
    logic       have_last_r;
    logic [6:0] pend_pat_r;
    logic       have_pend_r;
    state_t     state_r;
    state_t     state_s;

    logic       out_valid_r;
    logic [3:0] out_nibble_r;
    logic       out_dash_r;
    logic       out_blank_r;
    logic       out_err_r;
    logic       out_overrun_r;

    logic       stable_s;
    logic       new_s;
    logic       load_s;
    logic       pend_set_s;
    logic       pend_clr_s;
    logic       overrun_s;
    logic [6:0] dec_s;

    // Sample register and stability counter; any change restarts the filter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q_r <= 7'h7F;
            cnt_r   <= 8'd0;
        end else begin
            seg_q_r <= seg_in;
            if (seg_in != seg_q_r) begin
                cnt_r <= 8'd0;
            end else if (cnt_r != STAB_MAX) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Stability, novelty and decode of the registered sample.
    always_comb begin
        stable_s = (cnt_r == STAB_MAX);
        new_s    = stable_s && (!have_last_r || (seg_q_r != last_pat_r));
        dec_s    = decode_seg(~seg_q_r);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, load strobe and pending/overrun bookkeeping.
    always_comb begin
        state_s    = state_r;
        load_s     = 1'b0;
        pend_set_s = 1'b0;
        pend_clr_s = 1'b0;
        overrun_s  = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (new_s) begin
                    load_s  = 1'b1;
                    state_s = ST_FULL;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // Only the first stable cycle of a fresh pattern records it.
                if (new_s && !(have_pend_r && (seg_q_r == pend_pat_r))) begin
                    pend_set_s = 1'b1;
                    overrun_s  = have_pend_r;
                end else begin
                    pend_set_s = 1'b0;
                end
                if (out_ready) begin
                    state_s    = ST_EMPTY;
                    pend_clr_s = 1'b1;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: begin
                state_s = ST_EMPTY;
            end
        endcase
    end

    // Pending pattern tracker used only for overrun detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_pat_r  <= 7'h00;
            have_pend_r <= 1'b0;
        end else if (pend_clr_s) begin
            pend_pat_r  <= pend_pat_r;
            have_pend_r <= 1'b0;
        end else if (pend_set_s) begin
            pend_pat_r  <= seg_q_r;
            have_pend_r <= 1'b1;
        end else begin
            pend_pat_r  <= pend_pat_r;
            have_pend_r <= have_pend_r;
        end
    end

    // Result registers, loaded only on the EMPTY to FULL transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r   <= 1'b0;
            out_nibble_r  <= 4'h0;
            out_dash_r    <= 1'b0;
            out_blank_r   <= 1'b0;
            out_err_r     <= 1'b0;
            out_overrun_r <= 1'b0;
            last_pat_r    <= 7'h00;
            have_last_r   <= 1'b0;
        end else begin
            out_valid_r   <= (state_s == ST_FULL);
            out_overrun_r <= overrun_s;
            if (load_s) begin
                out_nibble_r <= dec_s[3:0];
                out_dash_r   <= dec_s[4];
                out_blank_r  <= dec_s[5];
                out_err_r    <= dec_s[6];
                last_pat_r   <= seg_q_r;
                have_last_r  <= 1'b1;
            end else begin
                out_nibble_r <= out_nibble_r;
                out_dash_r   <= out_dash_r;
                out_blank_r  <= out_blank_r;
                out_err_r    <= out_err_r;
                last_pat_r   <= last_pat_r;
                have_last_r  <= have_last_r;
            end
        end
    end

`ifdef SSD_DECODE_ERR_CNT_EN
    logic [7:0] err_count_r;

    // Saturating count of emitted invalid patterns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count_r <= 8'd0;
        end else if (load_s && dec_s[6] && (err_count_r != 8'd255)) begin
            err_count_r <= err_count_r + 8'd1;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign err_count = err_count_r;
`else
    assign err_count = 8'd0;
`endif

    assign out_valid   = out_valid_r;
    assign out_nibble  = out_nibble_r;
    assign out_dash    = out_dash_r;
    assign out_blank   = out_blank_r;
    assign out_err     = out_err_r;
    assign out_overrun = out_overrun_r;

endmodule

// File: tb/tb_ssd_segment_decoder.sv
// Directed self-checking bench for ssd_segment_decoder (STABLE_CYCLES = 4).
module tb_ssd_segment_decoder;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_nibble;
    logic       out_dash;
    logic       out_blank;
    logic       out_err;
    logic       out_overrun;
    logic [7:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;
    int hs_cnt = 0;
    int ovr_cnt = 0;
    logic [3:0] hs_nib = 4'h0;
    int base;

    logic [6:0] codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    ssd_segment_decoder #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_nibble  (out_nibble),
        .out_dash    (out_dash),
        .out_blank   (out_blank),
        .out_err     (out_err),
        .out_overrun (out_overrun),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observes handshakes and overrun pulses.
    always @(posedge clk) begin
        if (out_valid && out_ready) begin
            hs_cnt <= hs_cnt + 1;
            hs_nib <= out_nibble;
        end
        if (out_overrun) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        seg_in    = 7'h7F;
        out_ready = 1'b0;
        step(2);
        chk("rst_valid", out_valid, 0);
        chk("rst_nibble", out_nibble, 0);
        chk("rst_dash", out_dash, 0);
        chk("rst_blank", out_blank, 0);
        chk("rst_err", out_err, 0);
        chk("rst_overrun", out_overrun, 0);
        chk("rst_errcnt", err_count, 0);

        // Digit sweep with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rst_n  = 1'b1;
            seg_in = ~codes[i];
            step(4);
            chk("sweep_early", out_valid, 0);
            step(1);
            chk("sweep_valid", out_valid, 1);
            chk("sweep_nibble", out_nibble, i);
            chk("sweep_err", out_err, 0);
            step(5);
        end
        chk("sweep_count", hs_cnt, 16);

        seg_in = ~7'h40;
        step(4);
        chk("dash_early", out_valid, 0);
        step(1);
        chk("dash_valid", out_valid, 1);
        chk("dash_flag", out_dash, 1);
        chk("dash_nibble", out_nibble, 0);
        chk("dash_err", out_err, 0);
        step(5);

        seg_in = 7'h7F;
        step(5);
        chk("blank_valid", out_valid, 1);
        chk("blank_flag", out_blank, 1);
        chk("blank_dash", out_dash, 0);
        step(5);

        seg_in = ~7'h2A;
        step(5);
        chk("inv_valid", out_valid, 1);
        chk("inv_err", out_err, 1);
        chk("inv_nibble", out_nibble, 0);
        chk("inv_blank", out_blank, 0);
`ifdef SSD_DECODE_ERR_CNT_EN
        chk("inv_errcnt", err_count, 1);
`else
        chk("inv_errcnt", err_count, 0);
`endif
        step(5);

        // Short glitch must not produce a result.
        seg_in = ~7'h06;
        step(5);
        chk("glitch_one", out_nibble, 1);
        step(5);
        base   = hs_cnt;
        seg_in = ~7'h5B;
        step(3);
        seg_in = ~7'h06;
        step(10);
        chk("glitch_none", hs_cnt - base, 0);
        chk("glitch_valid", out_valid, 0);

        // Backpressure with two superseding patterns.
        out_ready = 1'b0;
        base   = ovr_cnt;
        seg_in = ~7'h4F;
        step(4);
        chk("bp_early", out_valid, 0);
        step(1);
        chk("bp_valid3", out_valid, 1);
        chk("bp_nib3", out_nibble, 3);
        seg_in = ~7'h07;
        step(8);
        chk("bp_no_ovr", ovr_cnt - base, 0);
        chk("bp_hold3", out_nibble, 3);
        seg_in = ~7'h67;
        step(8);
        chk("bp_ovr_once", ovr_cnt - base, 1);
        chk("bp_ovr_low", out_overrun, 0);
        chk("bp_still3", out_nibble, 3);
        chk("bp_still_v", out_valid, 1);
        out_ready = 1'b1;
        step(1);
        chk("bp_acc_v", out_valid, 0);
        chk("bp_acc_nib", hs_nib, 3);
        step(1);
        chk("bp_nine_v", out_valid, 1);
        chk("bp_nine", out_nibble, 9);
        step(1);
        chk("bp_nine_acc", hs_nib, 9);
        chk("bp_nine_done", out_valid, 0);

        // Reset while a result is waiting.
        out_ready = 1'b0;
        seg_in = ~7'h6D;
        step(5);
        chk("rmh_valid", out_valid, 1);
        chk("rmh_nib", out_nibble, 5);
        rst_n = 1'b0;
        step(1);
        chk("rmh_rst_v", out_valid, 0);
        chk("rmh_rst_nib", out_nibble, 0);
        chk("rmh_rst_err", out_err, 0);
        chk("rmh_rst_blank", out_blank, 0);
        chk("rmh_rst_cnt", err_count, 0);
        rst_n = 1'b1;
        step(4);
        chk("rmh_early", out_valid, 0);
        step(1);
        chk("rmh_reemit_v", out_valid, 1);
        chk("rmh_reemit", out_nibble, 5);
        out_ready = 1'b1;
        step(2);

        // Long hold yields exactly one result.
        base   = hs_cnt;
        seg_in = ~7'h66;
        step(100);
        chk("rep_once", hs_cnt - base, 1);
        chk("rep_nib", hs_nib, 4);
        chk("rep_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ssd_segment_decoder.md
# ssd_segment_decoder

Receive-side counterpart to the hex-to-seven-segment encoder. The block samples an active-low 7-bit segment bus, such as a looped-back SSD drive or a captured display bus, and waits until the pattern has been stable for a programmable number of cycles. It then decodes the pattern back to a hex nibble, a dash flag or a blank flag, or flags it as invalid. Each new stable pattern is presented once on a valid/ready output port; the display self-test and the arbitrage-engine debug monitor consume it.

## Interface
Parameters:
- STABLE_CYCLES, default 4: number of consecutive identical samples required before a pattern is accepted. Legal range 2..255.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- seg_in  input  7  segment bus, active low; bit0 = segment a … bit6 = segment g.
- out_valid  output  1  decoded result is available.
- out_ready  input  1  consumer accepts the result when out_valid is high.
- out_nibble  output  4  decoded hex digit; 0 when the result is not a digit.
- out_dash  output  1  pattern is a single dash (segment g only).
- out_blank  output  1  all segments are off.
- out_err  output  1  pattern matches no legal code.
- out_overrun  output  1  one-cycle pulse: an unconsumed stable pattern was superseded.
- err_count  output  8  count of invalid patterns seen (see Configuration).

## Operation
- Decode acts on raw = ~seg_in_q, the active-high form of the registered sample.
- Digit codes in raw hex: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:67 A:77 B:7C C:39 D:5E E:79 F:71.
- Non-digit codes: dash 40, blank 00. Any other raw value sets out_err.
- Exactly one of {digit, dash, blank, err} is true per result. out_nibble is 0 unless the result is a digit.
- Stability filter:
  - seg_q is loaded from seg_in every cycle.
  - cnt (8 bits) clears to 0 when seg_in != seg_q. Otherwise it increments, saturating at STABLE_CYCLES-1.
  - The sample is "stable" when cnt == STABLE_CYCLES-1.
- Change detection:
  - last_pat holds the most recently emitted pattern; have_last is its validity bit and resets to 0.
  - A stable pattern is "new" when have_last==0 or seg_q != last_pat.
- State machine:
  - EMPTY: when a new stable pattern is present, load the output registers, set last_pat and have_last, assert out_valid, and go to FULL.
  - FULL: the output registers hold their values. When out_valid && out_ready, deassert out_valid and go to EMPTY.
  - FULL with a different new stable pattern: if that pattern stays stable until acceptance, it is emitted from EMPTY on the following cycle. A pattern that is emitted is not re-emitted while it stays stable.
- Overrun: while in FULL, when the filter reaches stability on a pattern that differs from both last_pat and the previously recorded pending pattern, out_overrun pulses for 1 cycle. The pending pattern is replaced by the newest one, and only the newest is emitted after acceptance.
- Reset has priority over every other event, including an in-flight handshake. A result pending at reset is discarded.

## Timing
- Reset values: out_valid=0, out_nibble=0, out_dash=0, out_blank=0, out_err=0, out_overrun=0, err_count=0; cnt=0, have_last=0, seg_q=7'h7F.
- Latency: if seg_in changes before edge k and then holds, out_valid rises at edge k+STABLE_CYCLES, provided the FSM is in EMPTY.
- Throughput: at most one result per 2 cycles. The EMPTY→FULL transition takes 1 cycle and acceptance takes 1 cycle.
- A glitch shorter than STABLE_CYCLES samples is never reported. The filter restarts on each change.
- out_ready is ignored while out_valid=0. The output registers change only on EMPTY→FULL.

## Configuration
- SSD_DECODE_ERR_CNT_EN defined: err_count increments, saturating at 255, on each emitted result with out_err=1. It is cleared only by reset.
- SSD_DECODE_ERR_CNT_EN undefined: err_count is constant 0 and no counter logic is built.

## Test plan
- Digit sweep: drive each active-low code ~3F … ~71 for 10 cycles with out_ready=1 → out_valid rises 4 cycles after the change, and out_nibble is 0…F in order.
- Dash, blank and invalid: drive ~40 → out_dash=1. Drive 7'h7F → out_blank=1. Drive ~2A → out_err=1, and with the macro defined err_count=1.
- Glitch rejection: hold ~06, then pulse ~5B for 3 cycles, then return to ~06 → no new result after the first "1".
- Backpressure: out_ready=0, emit "3", then change the input to stable "7" and then stable "9" → out_overrun pulses once; on out_ready=1, "3" is accepted and then "9" is emitted.
- Reset mid-handshake: assert rst_n=0 while out_valid=1 → the next cycle has all outputs 0; after release, the same stable input is re-emitted because have_last=0.
- Repeat suppression: hold ~66 for 100 cycles → exactly one result with out_nibble=4.
